// File: rtl/button_debouncer.sv
// button_debouncer: 2-FF synchroniser plus 4-state stability FSM; optional glitch counter via BTN_DEBOUNCE_GLITCH_CNT_EN
module button_debouncer #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W = $clog2(STABLE_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_clean,
  output logic btn_sync
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);
  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic sync1, sync2;
  state_t state;
  logic [CNT_W-1:0] cnt;
  assign btn_sync = sync2;
  // bring the raw level into the clk domain; nothing may sit between the two flops
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  // qualify each level change for STABLE_CYCLES samples; btn_clean registered alongside the state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE_LO;
      cnt <= '0;
      btn_clean <= 1'b0;
    end else begin
      case (state)
        IDLE_LO:
          if (sync2) begin
            state <= WAIT_HI;
            cnt <= CNT_W'(1);
          end else cnt <= '0;
        WAIT_HI:
          if (!sync2) begin
            state <= IDLE_LO;
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE_HI;
            cnt <= '0;
            btn_clean <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
        IDLE_HI:
          if (!sync2) begin
            state <= WAIT_LO;
            cnt <= CNT_W'(1);
          end
        WAIT_LO:
          if (sync2) begin
            state <= IDLE_HI;
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE_LO;
            cnt <= '0;
            btn_clean <= 1'b0;
          end else cnt <= cnt + CNT_W'(1);
        default: begin
          state <= IDLE_LO;
          cnt <= '0;
          btn_clean <= 1'b0;
        end
      endcase
    end
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
  logic abort;
  assign abort = (state == WAIT_HI && !sync2) || (state == WAIT_LO && sync2);
  // count aborted qualifications, saturating so a noisy line never appears clean again
  always_ff @(posedge clk or posedge reset)
    if (reset) glitch_cnt <= '0;
    else if (abort && glitch_cnt != 8'hff) glitch_cnt <= glitch_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed checks of debounce latency, filtering, async reset and glitch counting
module tb_button_debouncer;
  logic clk = 1'b0, reset = 1'b1, btn_in = 1'b0, btn_in2 = 1'b0;
  logic btn_clean, btn_sync, clean2, sync2;
  int checks = 0, errors = 0, rises = 0;
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt, glitch2;
`endif
  button_debouncer #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_clean(btn_clean), .btn_sync(btn_sync)
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt)
`endif
  );
  button_debouncer #(.STABLE_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .btn_in(btn_in2), .btn_clean(clean2), .btn_sync(sync2)
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(glitch2)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge btn_clean) rises++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    logic [4:0] bounce;
    bounce = 5'b10101;
    @(negedge clk);
    check("rst_clean", btn_clean, 0);
    check("rst_sync", btn_sync, 0);
    reset = 1'b0;
    step(10);
    check("idle_quiet", btn_clean, 0);
    // async reset while high, then re-qualify a held button
    btn_in = 1'b1;
    step(8);
    check("t1_high", btn_clean, 1);
    check("t1_sync_high", btn_sync, 1);
    #3 reset = 1'b1;
    #1;
    check("t1_async_clean", btn_clean, 0);
    check("t1_async_sync", btn_sync, 0);
    @(negedge clk);
    reset = 1'b0;
    step(5);
    check("t1_edge5", btn_clean, 0);
    step(1);
    check("t1_edge6", btn_clean, 1);
    // clean press and release
    btn_in = 1'b0;
    do_reset();
    rises = 0;
    btn_in = 1'b1;
    step(5);
    check("t2_edge5", btn_clean, 0);
    step(1);
    check("t2_edge6", btn_clean, 1);
    step(14);
    check("t2_held", btn_clean, 1);
    check("t2_rises", rises, 1);
    btn_in = 1'b0;
    step(5);
    check("t2_rel5", btn_clean, 1);
    step(1);
    check("t2_rel6", btn_clean, 0);
    // bounce 1,0,1,0,1 then held
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      btn_in = bounce[i];
      step(1);
      check("t3_bounce", btn_clean, 0);
    end
    step(4);
    check("t3_edge5", btn_clean, 0);
    step(1);
    check("t3_edge6", btn_clean, 1);
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
    check("t3_glitch", glitch_cnt, 2);
`endif
    // three-sample glitch is filtered
    btn_in = 1'b0;
    do_reset();
    rises = 0;
    btn_in = 1'b1;
    step(3);
    btn_in = 1'b0;
    step(10);
    check("t4_short", btn_clean, 0);
    check("t4_short_rises", rises, 0);
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
    check("t4_glitch", glitch_cnt, 1);
`endif
    // four-sample pulse qualifies
    do_reset();
    rises = 0;
    btn_in = 1'b1;
    step(4);
    btn_in = 1'b0;
    step(2);
    check("t4_pulse_hi", btn_clean, 1);
    step(3);
    check("t4_pulse_hold", btn_clean, 1);
    step(1);
    check("t4_pulse_lo", btn_clean, 0);
    check("t4_pulse_rises", rises, 1);
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
    check("t4_pulse_glitch", glitch_cnt, 0);
`endif
    // reset while in WAIT_LO
    do_reset();
    btn_in = 1'b1;
    step(6);
    check("t5_high", btn_clean, 1);
    btn_in = 1'b0;
    step(3);
    check("t5_waitlo", btn_clean, 1);
    btn_in = 1'b1;
    #3 reset = 1'b1;
    #1;
    check("t5_async", btn_clean, 0);
    @(negedge clk);
    reset = 1'b0;
    step(5);
    check("t5_edge5", btn_clean, 0);
    step(1);
    check("t5_edge6", btn_clean, 1);
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
    // saturation after many aborts
    btn_in = 1'b0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      btn_in = 1'b1;
      step(1);
      btn_in = 1'b0;
      step(1);
    end
    step(4);
    check("t6_glitch100", glitch_cnt, 100);
    for (int i = 0; i < 200; i++) begin
      btn_in = 1'b1;
      step(1);
      btn_in = 1'b0;
      step(1);
    end
    step(4);
    check("t6_glitch_sat", glitch_cnt, 255);
    check("t6_clean", btn_clean, 0);
`endif
    // two-sample build
    btn_in2 = 1'b0;
    do_reset();
    btn_in2 = 1'b1;
    step(3);
    check("t6_s2_edge3", clean2, 0);
    step(1);
    check("t6_s2_edge4", clean2, 1);
    btn_in2 = 1'b0;
    step(3);
    check("t6_s2_rel3", clean2, 1);
    step(1);
    check("t6_s2_rel4", clean2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
